perf_event_counter_bank: RTL and testbench

- Parametrised performance-counter bank, successor to the current special-register counters.
- Sits beside the decode stage and watches the retiring instruction stream.
- Keeps six event counters: cycles, instructions, arithmetic, memory, stall and vector.
- Adds configurable counter width, wrap or saturate mode, sticky overflow flags, synchronous clear, a snapshot shadow bank, and a registered read port.

---
 rtl/perf_event_counter_bank_pkg.sv | 49 ++++
 rtl/perf_event_counter_bank_cell.sv | 31 +++
 rtl/perf_event_counter_bank.sv | 101 ++++++++++
 tb/tb_perf_event_counter_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_event_counter_bank_pkg.sv
// Shared event encoding and instruction decode for the performance counter bank.
package perf_pkg;

  typedef enum logic [2:0] {
    CYC   = 3'd0,
    INSTR = 3'd1,
    ARITH = 3'd2,
    MEM   = 3'd3,
    STALL = 3'd4,
    VEC   = 3'd5
  } perf_evt_e;

  localparam int NUM_EVT = 6;

  localparam logic [1:0] TYPE_MEM  = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CTRL = 2'b10;
  localparam logic [1:0] TYPE_VEC  = 2'b11;

  // Data-type opcodes with op[4]=0 in this range count as stalls.
  localparam logic [4:0] STALL_OP_LO = 5'd5;
  localparam logic [4:0] STALL_OP_HI = 5'd7;

  // Event increment mask for one retiring instruction (cycle bit never set here).
  function automatic logic [NUM_EVT-1:0] decode_evt(input logic [1:0] typ,
                                                   input logic [4:0] op);
    logic [NUM_EVT-1:0] m;
    m = '0;
    case (typ)
      TYPE_MEM: begin
        m[INSTR] = 1'b1;
        m[MEM]   = 1'b1;
      end
      TYPE_DATA: begin
        m[INSTR] = 1'b1;
        if (op[4] || op < STALL_OP_LO) m[ARITH] = 1'b1;
        else if (op <= STALL_OP_HI)    m[STALL] = 1'b1;
      end
      TYPE_VEC: begin
        m[INSTR] = 1'b1;
        m[ARITH] = 1'b1;
        m[VEC]   = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/perf_event_counter_bank_cell.sv
// One event counter with its sticky overflow flag; wraps or saturates.
module perf_counter_cell #(
  parameter int CNT_W    = 19,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
        cnt <= SATURATE ? cnt : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_event_counter_bank.sv
// Six-event performance counter bank: 2-stage decode/count, shadow snapshot, registered read.
module perf_event_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W    = 19,
  parameter bit SATURATE = 1'b0,
  parameter bit SNAP_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [1:0]       instruction_type,
  input  logic [4:0]       opcode,
  input  logic             finish,
  input  logic             clear,
  input  logic             snapshot_req,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  input  logic             rd_shadow,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [5:0]       ovf,
  output logic             snap_valid
);

  logic                              s1_vld;
  logic [1:0]                        s1_type;
  logic [4:0]                        s1_op;
  logic [NUM_EVT-1:0]                inc;
  logic [NUM_EVT-1:0][CNT_W-1:0]     live;
  logic [NUM_EVT-1:0][CNT_W-1:0]     shadow;
  logic [CNT_W-1:0]                  rd_mux;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_type <= '0;
      s1_op   <= '0;
    end else if (clear) begin
      s1_vld  <= 1'b0;
    end else if (!finish) begin
      s1_vld  <= instr_valid;
      s1_type <= instruction_type;
      s1_op   <= opcode;
    end
  end

  always_comb begin
    inc = '0;
    if (!finish) begin
      if (s1_vld) inc = decode_evt(s1_type, s1_op);
      inc[CYC] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_cell
    perf_counter_cell #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (inc[g]),
      .cnt (live[g]),
      .ovf (ovf[g])
    );
  end

  if (SNAP_EN) begin : g_snap
    // Shadows sample live values before this edge's increments land.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        shadow     <= '0;
        snap_valid <= 1'b0;
      end else if (clear) begin
        shadow     <= '0;
        snap_valid <= 1'b0;
      end else if (snapshot_req) begin
        shadow     <= live;
        snap_valid <= 1'b1;
      end
    end
  end else begin : g_nosnap
    assign shadow     = '0;
    assign snap_valid = 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    if (rd_sel < 3'(NUM_EVT)) rd_mux = rd_shadow ? shadow[rd_sel] : live[rd_sel];
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= clear ? '0 : rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Randomized and directed bench for perf_event_counter_bank against an event-total reference model.
module tb_perf_event_counter_bank;
  localparam int W = 19;

  logic clk = 1'b1, rst = 1'b0;
  logic instr_valid = 0, finish = 0, clear = 0, snapshot_req = 0, rd_en = 0, rd_shadow = 0;
  logic [1:0] instruction_type = '0;
  logic [4:0] opcode = '0;
  logic [2:0] rd_sel = '0;

  logic [W-1:0] rd_data;
  logic [3:0]   rd_data_w, rd_data_s;
  logic         rd_valid, rd_valid_w, rd_valid_s, snap_valid, snap_w, snap_s;
  logic [5:0]   ovf, ovf_w, ovf_s;

  perf_event_counter_bank dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction_type(instruction_type),
    .opcode(opcode), .finish(finish), .clear(clear), .snapshot_req(snapshot_req),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd_data),
    .rd_valid(rd_valid), .ovf(ovf), .snap_valid(snap_valid));

  perf_event_counter_bank #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction_type(instruction_type),
    .opcode(opcode), .finish(finish), .clear(clear), .snapshot_req(snapshot_req),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd_data_w),
    .rd_valid(rd_valid_w), .ovf(ovf_w), .snap_valid(snap_w));

  perf_event_counter_bank #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction_type(instruction_type),
    .opcode(opcode), .finish(finish), .clear(clear), .snapshot_req(snapshot_req),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_shadow(rd_shadow), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .ovf(ovf_s), .snap_valid(snap_s));

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;

  // Model: number of increments each event has received since the last clear/reset.
  longint tot[6], shtot[6], rd_tot;
  bit snap_v, rv, p_vld;
  logic [1:0] p_ty;
  logic [4:0] p_op;

  function automatic longint expv(input longint t, input int w, input bit sat);
    longint lim = longint'(1) << w;
    if (t < lim) return t;
    return sat ? lim - 1 : t % lim;
  endfunction

  function automatic logic [5:0] expovf(input int w);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = (tot[i] >= (longint'(1) << w));
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin tot[i] = 0; shtot[i] = 0; end
    rd_tot = 0; snap_v = 0; rv = 0; p_vld = 0; p_ty = '0; p_op = '0;
  endtask

  task automatic model_step();
    rv = rd_en;
    if (clear) begin
      if (rd_en) rd_tot = 0;
      for (int i = 0; i < 6; i++) begin tot[i] = 0; shtot[i] = 0; end
      snap_v = 0; p_vld = 0;
    end else begin
      if (rd_en) rd_tot = (rd_sel > 5) ? 0 : (rd_shadow ? shtot[rd_sel] : tot[rd_sel]);
      if (snapshot_req) begin shtot = tot; snap_v = 1; end
      if (!finish) begin
        tot[0]++;
        if (p_vld) case (p_ty)
          2'b00: begin tot[1]++; tot[3]++; end
          2'b01: begin
            tot[1]++;
            if (p_op >= 16 || p_op <= 4) tot[2]++;
            else if (p_op <= 7) tot[4]++;
          end
          2'b11: begin tot[1]++; tot[2]++; tot[5]++; end
          default: ;
        endcase
        p_vld = instr_valid; p_ty = instruction_type; p_op = opcode;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] ty, input logic [4:0] op, input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1; instruction_type = ty; opcode = op;
      cycle();
    end
    instr_valid = 0;
  endtask

  task automatic rd(input logic [2:0] sel, input logic sh);
    rd_en = 1; rd_sel = sel; rd_shadow = sh;
    cycle();
    rd_en = 0; rd_shadow = 0;
  endtask

  task automatic do_clear();
    clear = 1; cycle(); clear = 0;
  endtask

  task automatic test_reset();
    #12;
    ntot++; if (rd_data !== '0 || rd_valid !== 0) $display("FAIL reset_rd got %0d/%0b want 0/0", rd_data, rd_valid); else npass++;
    ntot++; if (ovf !== '0 || snap_valid !== 0) $display("FAIL reset_flags got %b/%b want 0/0", ovf, snap_valid); else npass++;
    rst = 1;
    model_reset();
    rd(3'd1, 1'b0);
    ntot++; if (rd_data !== '0 || rd_valid !== 1) $display("FAIL reset_read got %0d/%0b want 0/1", rd_data, rd_valid); else npass++;
  endtask

  task automatic test_arith_stream();
    do_clear();
    issue(2'b01, 5'd0, 10);
    cycle(); cycle();
    rd(3'd1, 0);
    ntot++; if (rd_data !== W'(10)) $display("FAIL arith_instr got %0d want 10", rd_data); else npass++;
    rd(3'd2, 0);
    ntot++; if (rd_data !== W'(10)) $display("FAIL arith_arith got %0d want 10", rd_data); else npass++;
    rd(3'd3, 0);
    ntot++; if (rd_data !== W'(0)) $display("FAIL arith_mem got %0d want 0", rd_data); else npass++;
    rd(3'd0, 0);
    ntot++; if (rd_data < W'(10) || rd_data !== W'(rd_tot)) $display("FAIL arith_cyc got %0d want %0d", rd_data, rd_tot); else npass++;
    cycle();
    ntot++; if (rd_valid !== 0 || rd_data !== W'(rd_tot)) $display("FAIL rd_hold got %0d/%0b want %0d/0", rd_data, rd_valid, rd_tot); else npass++;
  endtask

  task automatic test_mixed();
    logic [W-1:0] want [6];
    want = '{0, 6, 1, 3, 2, 1};
    do_clear();
    issue(2'b00, 5'd3, 3);
    issue(2'b01, 5'b00110, 2);
    issue(2'b11, 5'b10010, 1);
    issue(2'b10, 5'd1, 1);
    cycle(); cycle();
    for (int s = 1; s < 6; s++) begin
      rd(3'(s), 0);
      ntot++; if (rd_data !== want[s]) $display("FAIL mixed_sel%0d got %0d want %0d", s, rd_data, want[s]); else npass++;
    end
    rd(3'd6, 0);
    ntot++; if (rd_data !== '0) $display("FAIL mixed_sel6 got %0d want 0", rd_data); else npass++;
  endtask

  task automatic test_overflow();
    do_clear();
    issue(2'b01, 5'd1, 17);
    cycle(); cycle();
    rd(3'd2, 0);
    ntot++; if (rd_data_w !== 4'd1 || ovf_w[2] !== 1) $display("FAIL ovf_wrap got %0d/%b want 1/1", rd_data_w, ovf_w[2]); else npass++;
    ntot++; if (rd_data_s !== 4'd15 || ovf_s[2] !== 1) $display("FAIL ovf_sat got %0d/%b want 15/1", rd_data_s, ovf_s[2]); else npass++;
    ntot++; if (rd_data !== W'(17) || ovf !== 6'd0) $display("FAIL ovf_wide got %0d/%b want 17/0", rd_data, ovf); else npass++;
  endtask

  task automatic test_finish();
    do_clear();
    issue(2'b00, 5'd0, 5);
    cycle(); cycle();
    finish = 1;
    issue(2'b00, 5'd0, 4);
    rd(3'd3, 0);
    ntot++; if (rd_data !== W'(5)) $display("FAIL finish_mem got %0d want 5", rd_data); else npass++;
    rd(3'd0, 0);
    ntot++; if (rd_data !== W'(rd_tot)) $display("FAIL finish_cyc1 got %0d want %0d", rd_data, rd_tot); else npass++;
    cycle(); cycle();
    rd(3'd0, 0);
    ntot++; if (rd_data !== W'(rd_tot) || rd_data !== W'(tot[0])) $display("FAIL finish_cyc2 got %0d want %0d", rd_data, rd_tot); else npass++;
    finish = 0;
    issue(2'b00, 5'd0, 3);
    cycle(); cycle();
    rd(3'd3, 0);
    ntot++; if (rd_data !== W'(8)) $display("FAIL finish_resume got %0d want 8", rd_data); else npass++;
  endtask

  task automatic test_snapshot();
    do_clear();
    issue(2'b00, 5'd0, 7);
    cycle(); cycle();
    snapshot_req = 1; cycle(); snapshot_req = 0;
    issue(2'b00, 5'd0, 3);
    cycle(); cycle();
    rd(3'd1, 1);
    ntot++; if (rd_data !== W'(7)) $display("FAIL snap_shadow got %0d want 7", rd_data); else npass++;
    rd(3'd1, 0);
    ntot++; if (rd_data !== W'(10) || snap_valid !== 1) $display("FAIL snap_live got %0d/%b want 10/1", rd_data, snap_valid); else npass++;
    snapshot_req = 1; rd(3'd1, 1); snapshot_req = 0;
    ntot++; if (rd_data !== W'(7)) $display("FAIL snap_same_edge got %0d want 7", rd_data); else npass++;
    clear = 1; snapshot_req = 1; rd(3'd1, 0); clear = 0; snapshot_req = 0;
    ntot++; if (rd_data !== '0 || snap_valid !== 0 || ovf !== '0) $display("FAIL snap_clear got %0d/%b/%b want 0/0/0", rd_data, snap_valid, ovf); else npass++;
    rd(3'd1, 1);
    ntot++; if (rd_data !== '0) $display("FAIL snap_clear_shadow got %0d want 0", rd_data); else npass++;
  endtask

  task automatic test_async_reset();
    snapshot_req = 1; issue(2'b11, 5'd2, 1); snapshot_req = 0;
    rd_en = 1; rd_sel = 3'd1;
    issue(2'b11, 5'd2, 4);
    #2 rst = 0;
    #1;
    ntot++; if (rd_data !== '0 || rd_valid !== 0 || ovf !== '0 || snap_valid !== 0 || ovf_w !== '0)
      $display("FAIL async_rst got %0d/%b/%b/%b want all 0", rd_data, rd_valid, ovf, snap_valid); else npass++;
    model_reset();
    #1 rst = 1;
    issue(2'b00, 5'd0, 1);
    cycle();
    ntot++; if (rd_data !== '0 || rd_valid !== 1) $display("FAIL rst_latency1 got %0d want 0", rd_data); else npass++;
    cycle();
    ntot++; if (rd_data !== W'(1)) $display("FAIL rst_latency2 got %0d want 1", rd_data); else npass++;
    rd_en = 0;
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 600; n++) begin
      instr_valid      = 1'($urandom_range(0, 3) != 0);
      instruction_type = 2'($urandom);
      opcode           = 5'($urandom);
      finish           = ($urandom_range(0, 9) == 0);
      clear            = ($urandom_range(0, 39) == 0);
      snapshot_req     = ($urandom_range(0, 7) == 0);
      rd_en            = 1'($urandom);
      rd_sel           = 3'($urandom);
      rd_shadow        = 1'($urandom);
      cycle();
      ntot++; if (rd_valid !== rv || rd_data !== W'(expv(rd_tot, W, 0)))
        $display("FAIL rnd_rd n=%0d got %0d/%b want %0d/%b", n, rd_data, rd_valid, expv(rd_tot, W, 0), rv); else npass++;
      ntot++; if (ovf !== expovf(W) || snap_valid !== snap_v)
        $display("FAIL rnd_flags n=%0d got %b/%b want %b/%b", n, ovf, snap_valid, expovf(W), snap_v); else npass++;
      ntot++; if (rd_data_w !== 4'(expv(rd_tot, 4, 0)) || ovf_w !== expovf(4))
        $display("FAIL rnd_wrap n=%0d got %0d/%b want %0d/%b", n, rd_data_w, ovf_w, expv(rd_tot, 4, 0), expovf(4)); else npass++;
      ntot++; if (rd_data_s !== 4'(expv(rd_tot, 4, 1)) || ovf_s !== expovf(4))
        $display("FAIL rnd_sat n=%0d got %0d/%b want %0d/%b", n, rd_data_s, ovf_s, expv(rd_tot, 4, 1), expovf(4)); else npass++;
    end
    finish = 0; clear = 0; snapshot_req = 0; rd_en = 0; instr_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arith_stream();
    test_mixed();
    test_overflow();
    test_finish();
    test_snapshot();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
